// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - IorD select and memory-access sequencer for the multi-cycle core
// Arbitrates fetch/data requests against exception flags and strobes the IR/MDR/EPC/PC captures.
module mem_access_sequencer #(
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       fetch_req,
   input  logic       data_req,
   input  logic       data_we,
   input  logic       exc_opcode,
   input  logic       exc_ovf,
   input  logic       exc_div0,
   output logic [2:0] iord_sel,
   output logic       mem_wr,
   output logic       ir_write,
   output logic       mdr_write,
   output logic       epc_write,
   output logic       pc_vec_load,
   output logic [1:0] exc_cause,
   output logic       busy,
   output logic       done,
   output logic       double_fault
);

   typedef enum logic [2:0] {IDLE, FETCH, DATA, EXC_EPC, EXC_VEC} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q, we_d;
   logic             pend_q, pend_d;
   logic [1:0]       pend_cause_q, pend_cause_d;
   logic [1:0]       cause_q, cause_d;
   logic             dfault_q, dfault_d;

   logic             exc_any;
   logic [1:0]       cause_in;
   logic             last;

   always_comb begin
      exc_any = exc_opcode | exc_ovf | exc_div0;
      if (exc_opcode)    cause_in = 2'b01;
      else if (exc_ovf)  cause_in = 2'b10;
      else if (exc_div0) cause_in = 2'b11;
      else               cause_in = 2'b00;
      last = (cnt_q == LAST_CNT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         pend_q       <= 1'b0;
         pend_cause_q <= 2'b00;
         cause_q      <= 2'b00;
         dfault_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         pend_q       <= pend_d;
         pend_cause_q <= pend_cause_d;
         cause_q      <= cause_d;
         dfault_q     <= dfault_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 1'b1;
      we_d         = we_q;
      pend_d       = pend_q;
      pend_cause_d = pend_cause_q;
      cause_d      = cause_q;
      dfault_d     = dfault_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pend_q || exc_any) begin
               state_d = EXC_EPC;
               cause_d = pend_q ? pend_cause_q : cause_in;
            end else if (data_req) begin
               state_d = DATA;
               we_d    = data_we;
            end else if (fetch_req) begin
               state_d = FETCH;
            end
         end
         FETCH, DATA: begin
            // Exceptions raised mid-access wait until the access has finished.
            if (exc_any && !pend_q) begin
               pend_d       = 1'b1;
               pend_cause_d = cause_in;
            end
            if (last) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         EXC_EPC: begin
            if (exc_any) dfault_d = 1'b1;
            state_d = EXC_VEC;
            cnt_d   = '0;
         end
         EXC_VEC: begin
            if (exc_any) dfault_d = 1'b1;
            if (last) begin
               state_d = IDLE;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      iord_sel    = 3'b000;
      mem_wr      = 1'b0;
      ir_write    = 1'b0;
      mdr_write   = 1'b0;
      epc_write   = 1'b0;
      pc_vec_load = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (state_q)
         IDLE:  busy = 1'b0;
         FETCH: begin
            ir_write = last;
            done     = last;
         end
         DATA: begin
            iord_sel  = 3'b100;
            mem_wr    = we_q && (cnt_q == '0);
            mdr_write = !we_q && last;
            done      = last;
         end
         EXC_EPC: begin
            iord_sel  = {1'b0, cause_q};
            epc_write = 1'b1;
         end
         EXC_VEC: begin
            iord_sel    = {1'b0, cause_q};
            pc_vec_load = last;
            done        = last;
         end
         default: busy = 1'b0;
      endcase
   end

   assign exc_cause    = cause_q;
   assign double_fault = dfault_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - directed self-checking bench for mem_access_sequencer
// Output vector layout: {iord_sel[2:0], mem_wr, ir_write, mdr_write, epc_write, pc_vec_load, exc_cause[1:0], busy, done, double_fault}.
module tb_mem_access_sequencer;

   logic       clk;
   logic       reset_n;
   logic       fetch_req, data_req, data_we;
   logic       exc_opcode, exc_ovf, exc_div0;
   logic [2:0] iord_sel;
   logic       mem_wr, ir_write, mdr_write, epc_write, pc_vec_load;
   logic [1:0] exc_cause;
   logic       busy, done, double_fault;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [12:0] obs;
   assign obs = {iord_sel, mem_wr, ir_write, mdr_write, epc_write, pc_vec_load,
                 exc_cause, busy, done, double_fault};

   mem_access_sequencer #(.MEM_LAT(2), .CNT_W(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .fetch_req   (fetch_req),
      .data_req    (data_req),
      .data_we     (data_we),
      .exc_opcode  (exc_opcode),
      .exc_ovf     (exc_ovf),
      .exc_div0    (exc_div0),
      .iord_sel    (iord_sel),
      .mem_wr      (mem_wr),
      .ir_write    (ir_write),
      .mdr_write   (mdr_write),
      .epc_write   (epc_write),
      .pc_vec_load (pc_vec_load),
      .exc_cause   (exc_cause),
      .busy        (busy),
      .done        (done),
      .double_fault(double_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task test_reset;
      @(negedge clk);
      total_cnt++;
      if (obs !== 13'b0) $display("FAIL reset_state: got %b want %b", obs, 13'b0);
      else pass_cnt++;
      reset_n = 1'b1;
   endtask

   task test_fetch;
      logic [12:0] exp [0:4];
      exp[0] = 13'b000_00000_00_0_0_0;
      exp[1] = 13'b000_00000_00_1_0_0;
      exp[2] = 13'b000_00000_00_1_0_0;
      exp[3] = 13'b000_01000_00_1_1_0;
      exp[4] = 13'b000_00000_00_0_0_0;
      total_cnt++;
      if (obs !== exp[0]) $display("FAIL fetch c0: got %b want %b", obs, exp[0]);
      else pass_cnt++;
      fetch_req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         total_cnt++;
         if (obs !== exp[c]) $display("FAIL fetch c%0d: got %b want %b", c, obs, exp[c]);
         else pass_cnt++;
         if (c == 3) fetch_req = 1'b0;
      end
   endtask

   task test_store;
      logic [12:0] exp [1:4];
      exp[1] = 13'b100_10000_00_1_0_0;
      exp[2] = 13'b100_00000_00_1_0_0;
      exp[3] = 13'b100_00000_00_1_1_0;
      exp[4] = 13'b000_00000_00_0_0_0;
      data_req = 1'b1;
      data_we  = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         total_cnt++;
         if (obs !== exp[c]) $display("FAIL store c%0d: got %b want %b", c, obs, exp[c]);
         else pass_cnt++;
         if (c == 1) data_we = 1'b0;
         if (c == 3) data_req = 1'b0;
      end
   endtask

   task test_exc_priority;
      logic [12:0] exp [1:9];
      exp[1] = 13'b010_00010_10_1_0_0;
      exp[2] = 13'b010_00000_10_1_0_0;
      exp[3] = 13'b010_00000_10_1_0_0;
      exp[4] = 13'b010_00001_10_1_1_0;
      exp[5] = 13'b000_00000_10_0_0_0;
      exp[6] = 13'b100_00000_10_1_0_0;
      exp[7] = 13'b100_00000_10_1_0_0;
      exp[8] = 13'b100_00100_10_1_1_0;
      exp[9] = 13'b000_00000_10_0_0_0;
      fetch_req = 1'b1;
      data_req  = 1'b1;
      data_we   = 1'b0;
      exc_ovf   = 1'b1;
      exc_div0  = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         total_cnt++;
         if (obs !== exp[c]) $display("FAIL exc_priority c%0d: got %b want %b", c, obs, exp[c]);
         else pass_cnt++;
         if (c == 1) begin
            exc_ovf  = 1'b0;
            exc_div0 = 1'b0;
         end
         if (c == 8) begin
            fetch_req = 1'b0;
            data_req  = 1'b0;
         end
      end
   endtask

   task test_exc_during_fetch;
      logic [12:0] exp [1:9];
      exp[1] = 13'b000_00000_10_1_0_0;
      exp[2] = 13'b000_00000_10_1_0_0;
      exp[3] = 13'b000_01000_10_1_1_0;
      exp[4] = 13'b000_00000_10_0_0_0;
      exp[5] = 13'b001_00010_01_1_0_0;
      exp[6] = 13'b001_00000_01_1_0_0;
      exp[7] = 13'b001_00000_01_1_0_0;
      exp[8] = 13'b001_00001_01_1_1_0;
      exp[9] = 13'b000_00000_01_0_0_0;
      fetch_req = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         total_cnt++;
         if (obs !== exp[c]) $display("FAIL exc_pending c%0d: got %b want %b", c, obs, exp[c]);
         else pass_cnt++;
         if (c == 2) exc_opcode = 1'b1;
         if (c == 3) begin
            exc_opcode = 1'b0;
            fetch_req  = 1'b0;
         end
      end
   endtask

   task test_double_fault;
      logic [12:0] exp [1:6];
      exp[1] = 13'b011_00010_11_1_0_0;
      exp[2] = 13'b011_00000_11_1_0_0;
      exp[3] = 13'b011_00000_11_1_0_1;
      exp[4] = 13'b011_00001_11_1_1_1;
      exp[5] = 13'b000_00000_11_0_0_1;
      exp[6] = 13'b000_00000_11_0_0_1;
      exc_div0 = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         total_cnt++;
         if (obs !== exp[c]) $display("FAIL double_fault c%0d: got %b want %b", c, obs, exp[c]);
         else pass_cnt++;
         exc_div0 = (c == 2);
      end
   endtask

   task test_reset_mid_data;
      logic [12:0] exp [1:2];
      exp[1] = 13'b100_10000_11_1_0_1;
      exp[2] = 13'b100_00000_11_1_0_1;
      data_req = 1'b1;
      data_we  = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         total_cnt++;
         if (obs !== exp[c]) $display("FAIL reset_mid c%0d: got %b want %b", c, obs, exp[c]);
         else pass_cnt++;
      end
      #1 reset_n = 1'b0;
      #1;
      total_cnt++;
      if (obs !== 13'b0) $display("FAIL reset_async: got %b want %b", obs, 13'b0);
      else pass_cnt++;
      data_req = 1'b0;
      data_we  = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         total_cnt++;
         if (obs !== 13'b0) $display("FAIL reset_idle c%0d: got %b want %b", c, obs, 13'b0);
         else pass_cnt++;
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      fetch_req  = 1'b0;
      data_req   = 1'b0;
      data_we    = 1'b0;
      exc_opcode = 1'b0;
      exc_ovf    = 1'b0;
      exc_div0   = 1'b0;
      test_reset();
      test_fetch();
      test_store();
      test_exc_priority();
      test_exc_during_fetch();
      test_double_fault();
      test_reset_mid_data();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- FSM that drives the 3-bit IorD select of the memory-address mux and sequences every memory access of the multi-cycle core.
- Access types: instruction fetch (PC, 000), data load/store (RD, 100), and exception-vector reads (reg253/254/255 → 001/010/011).
- Arbitrates between main-control requests and exception flags, waits the memory latency, and strobes the capture registers (IR, MDR, PC).

Parameters:
- MEM_LAT, 2, memory read latency in cycles (legal range 1..15).
- CNT_W, 4, width of the latency counter; must hold MEM_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  main control requests an instruction fetch.
- data_req  in  1  main control requests a data access.
- data_we  in  1  qualifies data_req: 1 = store, 0 = load.
- exc_opcode  in  1  invalid opcode detected.
- exc_ovf  in  1  arithmetic overflow detected.
- exc_div0  in  1  divide by zero detected.
- iord_sel  out  3  select to the IorD mux.
- mem_wr  out  1  memory write strobe.
- ir_write  out  1  IR capture strobe.
- mdr_write  out  1  MDR capture strobe.
- epc_write  out  1  EPC capture strobe.
- pc_vec_load  out  1  PC load from memory data (exception vector).
- exc_cause  out  2  latched cause: 01 opcode, 10 overflow, 11 div0, 00 none.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an access sequence completes.
- double_fault  out  1  sticky flag; cleared only by reset.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, counter=0, pending exception cleared.
  - All outputs 0, including iord_sel=000.
  - Takes effect immediately, including mid-access; no partial strobes are emitted afterwards.
- States: IDLE, FETCH, DATA, EXC_EPC, EXC_VEC.
- IDLE:
  - iord_sel=000, busy=0.
  - Requests and exception flags are sampled at each rising edge.
  - Priority: exception (pending or present) > data_req > fetch_req.
- Exception cause priority among simultaneous flags: opcode (001/01) > overflow (010/10) > div0 (011/11).
- Exception arriving while busy outside the exception path:
  - Highest-priority cause is latched as pending.
  - Serviced from IDLE after the current sequence finishes; a store in progress still completes.
  - Further flags while an exception is pending are ignored.
- FETCH:
  - Lasts MEM_LAT+1 cycles with iord_sel=000.
  - ir_write=1 and done=1 in the last cycle only.
- DATA:
  - Lasts MEM_LAT+1 cycles with iord_sel=100.
  - Store: mem_wr=1 in the first cycle only; done in the last cycle.
  - Load: mdr_write=1 and done=1 in the last cycle.
  - data_we is sampled at acceptance and held internally.
- EXC_EPC:
  - One cycle: epc_write=1.
  - iord_sel=cause vector; exc_cause updated this cycle and held until the next exception.
- EXC_VEC:
  - Lasts MEM_LAT+1 cycles with iord_sel=cause vector.
  - pc_vec_load=1 and done=1 in the last cycle; pending cleared.
- Any exception flag during EXC_EPC or EXC_VEC: double_fault set (sticky); the flag is otherwise ignored.
- After any last cycle the FSM returns to IDLE; back-to-back requests therefore have one IDLE cycle between sequences.
- Counter: loads 0 on state entry, increments each cycle, and the last cycle is counter==MEM_LAT. No wrap within legal parameters.
- Encodings 101, 110 and 111 are never driven on iord_sel.
- Strobes are mutually exclusive per cycle.
- fetch_req and data_req are ignored when not in IDLE; requesters hold them until done.

Test Plan:
- Fetch with MEM_LAT=2: fetch_req high in cycle 0 → cycles 1-3 iord_sel=000, busy=1; ir_write=1 and done=1 in cycle 3 only; cycle 4 IDLE.
- Store: data_req=1, data_we=1 in cycle 0 → iord_sel=100 in cycles 1-3; mem_wr only in cycle 1; done in cycle 3; mdr_write never asserted.
- Simultaneous fetch_req, data_req (load) and exc_ovf+exc_div0 in cycle 0 → EXC_EPC in cycle 1 with epc_write=1, iord_sel=010, exc_cause=10; then EXC_VEC in cycles 2-4 with pc_vec_load in cycle 4; the load is serviced only if still requested afterwards.
- exc_opcode pulsed during FETCH cycle 2 → fetch completes with ir_write in cycle 3; IDLE in cycle 4; EXC_EPC in cycle 5 with iord_sel=001.
- exc_div0 pulsed during EXC_VEC → double_fault=1 and stays 1; the sequence completes unchanged with cause unchanged.
- reset_n low mid-DATA (cycle 2) → all outputs 0 immediately; after release with no requests, the FSM stays in IDLE with no strobes.
